// File: rtl/ram_peri_pkg.sv
// Shared types and helpers for the parametrised dual-port peripheral RAM.
package ram_peri_pkg;

  // Clear engine states: Clr zeroes the array, Idle serves accesses.
  typedef enum logic {
    ST_CLR  = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  // Number of byte lanes in a data word.
  function automatic int lane_cnt(input int data_len);
    return data_len / 8;
  endfunction

  // Data width must be a non-zero whole number of bytes.
  function automatic bit data_len_ok(input int data_len);
    return (data_len > 0) && ((data_len % 8) == 0);
  endfunction

endpackage

// File: rtl/ram_dp_core.sv
// Simple dual-port storage array: byte-lane write port, registered read port.
// The array itself has no reset so it maps onto block RAM; only the read
// data register is reset so the output starts at zero.
module ram_dp_core
  import ram_peri_pkg::*;
#(
  parameter int CAddrLen = 8,
  parameter int CDataLen = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CDataLen/8-1:0] wr_lane,
  input  logic [CAddrLen-1:0]   wr_addr,
  input  logic [CDataLen-1:0]   wr_data,
  input  logic                  rd_en,
  input  logic [CAddrLen-1:0]   rd_addr,
  output logic [CDataLen-1:0]   rd_data
);

  localparam int CLanes = lane_cnt(CDataLen);
  localparam int CDepth = 1 << CAddrLen;

  logic [CDataLen-1:0] mem [CDepth];

  // Per-lane write; lanes with a clear enable keep their contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CLanes; i++) begin
      if (wr_lane[i]) begin
        mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Synchronous read-first port; holds the last word when not reading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ram_dp_peri.sv
// Parametrised peripheral RAM: clear engine, byte-masked writes, collision
// forwarding and an optional output register around ram_dp_core.
// Handshake: there is no back-pressure. A write or read is accepted on an
// enabled edge whenever its strobe is high, the clear engine is idle and no
// clear is being requested; each accepted read yields exactly one ARdVld
// pulse 1 + COutReg enabled edges later, with AMiso valid in that cycle.
module ram_dp_peri
  import ram_peri_pkg::*;
#(
  parameter int CAddrLen = 8,
  parameter int CDataLen = 8,
  parameter int COutReg  = 0,
  parameter int CBypass  = 1
) (
  input  logic                  AClkH,
  input  logic                  AResetB,
  input  logic                  AClkHEn,
  input  logic                  AClrReq,
  input  logic                  AWrEn,
  input  logic [CDataLen/8-1:0] AWrMask,
  input  logic [CAddrLen-1:0]   AAddrWr,
  input  logic [CDataLen-1:0]   AMosi,
  input  logic                  ARdEn,
  input  logic [CAddrLen-1:0]   AAddrRd,
  output logic [CDataLen-1:0]   AMiso,
  output logic                  ARdVld,
  output logic                  ABusy
);

  localparam int                CLanes    = lane_cnt(CDataLen);
  localparam logic [CAddrLen-1:0] CLastAddr = '1;

  if (!data_len_ok(CDataLen)) begin : g_bad_width
    $error("ram_dp_peri: CDataLen must be a multiple of 8");
  end

  state_t              state, state_nxt;
  logic [CAddrLen-1:0] cnt, cnt_nxt;
  logic                busy, clr_wr, wr_acc, rd_acc;
  logic [CLanes-1:0]   mem_lane;
  logic [CAddrLen-1:0] mem_addr;
  logic [CDataLen-1:0] mem_data;
  logic [CDataLen-1:0] core_q, rd_word;
  logic                coll_q;
  logic [CLanes-1:0]   coll_lane_q;
  logic [CDataLen-1:0] coll_data_q;
  logic                vld1;

  assign busy   = (state == ST_CLR);
  assign clr_wr = AClkHEn && busy;
  // A clear request in Idle takes priority over any access in that cycle.
  assign wr_acc = AClkHEn && !busy && !AClrReq && AWrEn;
  assign rd_acc = AClkHEn && !busy && !AClrReq && ARdEn;
  assign ABusy  = busy;

  // Clear FSM and address counter register; reset restarts a full clear.
  always_ff @(posedge AClkH or negedge AResetB) begin
    if (!AResetB) begin
      state <= ST_CLR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: walk every address in Clr, enter Clr on request from Idle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (AClkHEn) begin
      case (state)
        ST_CLR: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == CLastAddr) state_nxt = ST_IDLE;
        end
        ST_IDLE: begin
          if (AClrReq) begin
            state_nxt = ST_CLR;
            cnt_nxt   = '0;
          end
        end
        default: state_nxt = ST_CLR;
      endcase
    end
  end

  // Write-port mux: the clear engine owns the port while busy.
  always_comb begin
    mem_lane = '0;
    mem_addr = AAddrWr;
    mem_data = AMosi;
    if (clr_wr) begin
      mem_lane = '1;
      mem_addr = cnt;
      mem_data = '0;
    end else if (wr_acc) begin
      mem_lane = AWrMask;
    end
  end

  ram_dp_core #(
    .CAddrLen(CAddrLen),
    .CDataLen(CDataLen)
  ) u_core (
    .clk     (AClkH),
    .rst_n   (AResetB),
    .wr_lane (mem_lane),
    .wr_addr (mem_addr),
    .wr_data (mem_data),
    .rd_en   (rd_acc),
    .rd_addr (AAddrRd),
    .rd_data (core_q)
  );

  // Capture collision info with each accepted read; held between reads so
  // the merged word stays stable while AMiso holds.
  always_ff @(posedge AClkH or negedge AResetB) begin
    if (!AResetB) begin
      coll_q      <= 1'b0;
      coll_lane_q <= '0;
      coll_data_q <= '0;
    end else if (rd_acc) begin
      coll_q      <= wr_acc && (AAddrWr == AAddrRd) && (CBypass != 0);
      coll_lane_q <= AWrMask;
      coll_data_q <= AMosi;
    end
  end

  // Bypass merge: the core returns old data, so patch in the written lanes.
  always_comb begin
    rd_word = core_q;
    if (coll_q) begin
      for (int i = 0; i < CLanes; i++) begin
        if (coll_lane_q[i]) rd_word[8*i +: 8] = coll_data_q[8*i +: 8];
      end
    end
  end

  // First valid stage, aligned with the core read register.
  always_ff @(posedge AClkH or negedge AResetB) begin
    if (!AResetB) begin
      vld1 <= 1'b0;
    end else if (AClkHEn) begin
      vld1 <= rd_acc;
    end
  end

  if (COutReg != 0) begin : g_out_reg
    logic [CDataLen-1:0] out_q;
    logic                vld2;

    // Extra output stage; data only moves when a valid word arrives.
    always_ff @(posedge AClkH or negedge AResetB) begin
      if (!AResetB) begin
        out_q <= '0;
        vld2  <= 1'b0;
      end else if (AClkHEn) begin
        vld2 <= vld1;
        if (vld1) out_q <= rd_word;
      end
    end

    assign AMiso  = out_q;
    assign ARdVld = vld2;
  end else begin : g_no_out_reg
    assign AMiso  = rd_word;
    assign ARdVld = vld1;
  end

endmodule

// File: tb/tb_ram_dp_peri.sv
// Bench for ram_dp_peri: two instances (write-first without output register,
// read-first with output register) share one stimulus stream and are checked
// against an array-based reference model of the RAM.
module tb_ram_dp_peri;

  logic        clk;
  logic        rst_n;
  logic        en, clr_req, wr_en, rd_en;
  logic [3:0]  wr_mask;
  logic [7:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [31:0] miso_a, miso_b;
  logic        vld_a, vld_b, busy_a, busy_b;

  ram_dp_peri #(.CAddrLen(8), .CDataLen(32), .COutReg(0), .CBypass(1)) dut_a (
    .AClkH(clk), .AResetB(rst_n), .AClkHEn(en), .AClrReq(clr_req),
    .AWrEn(wr_en), .AWrMask(wr_mask), .AAddrWr(wr_addr), .AMosi(wr_data),
    .ARdEn(rd_en), .AAddrRd(rd_addr), .AMiso(miso_a), .ARdVld(vld_a),
    .ABusy(busy_a)
  );

  ram_dp_peri #(.CAddrLen(8), .CDataLen(32), .COutReg(1), .CBypass(0)) dut_b (
    .AClkH(clk), .AResetB(rst_n), .AClkHEn(en), .AClrReq(clr_req),
    .AWrEn(wr_en), .AWrMask(wr_mask), .AAddrWr(wr_addr), .AMosi(wr_data),
    .ARdEn(rd_en), .AAddrRd(rd_addr), .AMiso(miso_b), .ARdVld(vld_b),
    .ABusy(busy_b)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  logic [31:0] mem [256];
  bit          m_busy;
  int          m_cnt;
  int          en_cnt;
  rd_t         qa[$];
  rd_t         qb[$];
  logic [31:0] last_a, last_b;
  bit          lv_a, lv_b;
  int          total, bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] m,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 1'b1;
    m_cnt  = 0;
    qa.delete();
    qb.delete();
    last_a = '0;
    last_b = '0;
    lv_a   = 1'b0;
    lv_b   = 1'b0;
  endtask

  // One enabled edge of the RAM, as seen from its rules.
  task automatic model_step();
    logic [31:0] old;
    if (!en) return;
    en_cnt++;
    if (m_busy) begin
      mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == 256) m_busy = 1'b0;
    end else if (clr_req) begin
      m_busy = 1'b1;
      m_cnt  = 0;
    end else begin
      if (rd_en) begin
        old = mem[rd_addr];
        qa.push_back('{en_cnt, (wr_en && wr_addr == rd_addr) ? merge(old, wr_mask, wr_data) : old});
        qb.push_back('{en_cnt + 1, old});
      end
      if (wr_en) mem[wr_addr] = merge(mem[wr_addr], wr_mask, wr_data);
    end
    lv_a = 1'b0;
    if (qa.size() > 0 && qa[0].due == en_cnt) begin
      last_a = qa[0].data;
      lv_a   = 1'b1;
      void'(qa.pop_front());
    end
    lv_b = 1'b0;
    if (qb.size() > 0 && qb[0].due == en_cnt) begin
      last_b = qb[0].data;
      lv_b   = 1'b1;
      void'(qb.pop_front());
    end
  endtask

  task automatic check_outputs();
    check_eq("busy_a", {31'b0, busy_a}, {31'b0, m_busy});
    check_eq("busy_b", {31'b0, busy_b}, {31'b0, m_busy});
    check_eq("vld_a", {31'b0, vld_a}, {31'b0, lv_a});
    check_eq("vld_b", {31'b0, vld_b}, {31'b0, lv_b});
    check_eq("miso_a", miso_a, last_a);
    check_eq("miso_b", miso_b, last_b);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit e, input bit c, input bit w, input logic [3:0] m,
                       input logic [7:0] aw, input logic [31:0] d, input bit r,
                       input logic [7:0] ar);
    en = e; clr_req = c; wr_en = w; wr_mask = m; wr_addr = aw; wr_data = d;
    rd_en = r; rd_addr = ar;
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    #1;
    check_outputs();
  endtask

  task automatic idle_cycle(input bit e);
    cycle(e, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [7:0] a, input logic [3:0] m, input logic [31:0] d);
    cycle(1'b1, 1'b0, 1'b1, m, a, d, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [7:0] a);
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, a);
  endtask

  task automatic rand_cycle(input int en_pct, input int clr_one_in);
    cycle($urandom_range(0, 99) < en_pct, $urandom_range(0, clr_one_in - 1) == 0,
          1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom_range(0, 15)), $urandom,
          1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)));
  endtask

  // Counts enabled edges until dut_a reports not busy (bounded).
  task automatic wait_clear_dut(output int n_en);
    int guard;
    bit e;
    guard = 0;
    n_en  = 0;
    while (busy_a === 1'b1 && guard < 3000) begin
      e = ($urandom_range(0, 9) != 0);
      cycle(e, 1'b0, 1'($urandom_range(0, 1)), 4'hF, 8'($urandom), $urandom,
            1'($urandom_range(0, 1)), 8'($urandom));
      if (e) n_en++;
      guard++;
    end
  endtask

  task automatic async_reset(input int hold_cycles);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (hold_cycles) idle_cycle(1'b1);
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    total = 0; bad = 0; en_cnt = 0;
    rst_n = 1'b0;
    en = 0; clr_req = 0; wr_en = 0; wr_mask = 0; wr_addr = 0; wr_data = 0;
    rd_en = 0; rd_addr = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    model_reset();

    repeat (3) idle_cycle(1'b1);
    rst_n = 1'b1;
    wait_clear_dut(n);
    check_eq("clr_len_boot", n, 256);

    // Cleared array reads back zero at the corners.
    rd(8'h00); rd(8'h7F); rd(8'hFF);
    idle_cycle(1'b1); idle_cycle(1'b1);

    // Byte-masked write.
    wr(8'h10, 4'hF, 32'hDEADBEEF);
    wr(8'h10, 4'b0101, 32'h11223344);
    rd(8'h10);
    check_eq("mask_word", miso_a, 32'hDE22BE44);
    idle_cycle(1'b1);
    check_eq("mask_word_reg", miso_b, 32'hDE22BE44);

    // Same-address collision.
    wr(8'h20, 4'hF, 32'h00000055);
    cycle(1'b1, 1'b0, 1'b1, 4'b0001, 8'h20, 32'h000000AA, 1'b1, 8'h20);
    check_eq("coll_bypass", miso_a, 32'h000000AA);
    rd(8'h20);
    check_eq("coll_old", miso_b, 32'h00000055);
    check_eq("after_coll_a", miso_a, 32'h000000AA);
    idle_cycle(1'b1);
    check_eq("after_coll_b", miso_b, 32'h000000AA);

    // Back-to-back reads through the output register.
    wr(8'h01, 4'hF, 32'h01010101);
    wr(8'h02, 4'hF, 32'h02020202);
    wr(8'h03, 4'hF, 32'h03030303);
    rd(8'h01); rd(8'h02); rd(8'h03);
    idle_cycle(1'b1); idle_cycle(1'b1);

    // Clock enable low mid-read freezes everything.
    rd(8'h02);
    repeat (3) idle_cycle(1'b0);
    idle_cycle(1'b1); idle_cycle(1'b1);

    // Randomised traffic with occasional clears.
    repeat (1500) rand_cycle(85, 400);
    n = 0;
    while (m_busy && n < 2000) begin idle_cycle(1'b1); n++; end

    // Clear request with a write, then reset part-way through the clear.
    wr(8'h05, 4'hF, 32'hCAFEF00D);
    cycle(1'b1, 1'b1, 1'b1, 4'hF, 8'h05, 32'h12345678, 1'b1, 8'h05);
    check_eq("clr_busy", {31'b0, busy_a}, 32'd1);
    n = 0;
    while (m_cnt < 100 && n < 2000) begin idle_cycle(1'b1); n++; end
    async_reset(2);
    wait_clear_dut(n);
    check_eq("clr_len_restart", n, 256);
    rd(8'h05);
    check_eq("addr5_zero", miso_a, 32'h0);
    idle_cycle(1'b1);
    check_eq("addr5_zero_reg", miso_b, 32'h0);
    repeat (3) idle_cycle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
